// File: rtl/fre_lst.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | fre_lst : circular free physical-register list, packed multi-port |
// |           release, all-or-nothing multi-port allocation            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fre_lst #(
  parameter int PREG_NUM     = 64,
  parameter int ARCH_REG_NUM = 16,
  parameter int PREG_BITS    = 6,
  parameter int REL_PORT     = 4,
  parameter int ALC_PORT     = 4,
  parameter int CAP          = PREG_NUM - ARCH_REG_NUM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REL_PORT*(PREG_BITS+1)-1:0] rel_flat,
  input  logic [2:0]                      alc_cnt,
  output logic                            alc_gnt,
  output logic [ALC_PORT*PREG_BITS-1:0]   alc_preg_flat,
  output logic [6:0]                      fre_cnt,
  output logic                            lst_emp,
  output logic                            ovf_err
);

  localparam int         c_rel_w   = PREG_BITS + 1;
  localparam logic [6:0] c_cap     = 7'(CAP);
  localparam logic [2:0] c_alc_max = 3'(ALC_PORT);

  logic [PREG_BITS-1:0] r_mem [PREG_NUM];
  logic [PREG_BITS-1:0] r_hd;
  logic [PREG_BITS-1:0] r_tl;
  logic [6:0]           r_fre_cnt;
  logic                 r_ovf;

  logic                 w_alc_gnt;
  logic [6:0]           w_granted;
  logic [6:0]           w_room;
  logic [6:0]           w_nrel_acc;
  logic                 w_ovf_now;
  logic [REL_PORT-1:0]  w_wr_en;
  logic [PREG_BITS-1:0] w_wr_idx [REL_PORT];
  logic [PREG_BITS-1:0] w_wr_dat [REL_PORT];

  // Grant is judged on the pre-edge count only; releases never forward.
  always_comb begin
    w_alc_gnt = (alc_cnt != 3'd0) && ({4'd0, alc_cnt} <= r_fre_cnt) &&
                (alc_cnt <= c_alc_max);
    w_granted = w_alc_gnt ? {4'd0, alc_cnt} : 7'd0;
    w_room    = c_cap - r_fre_cnt + w_granted;
  end

  // Compact valid release ports onto the tail; ports beyond the room are dropped.
  always_comb begin
    w_nrel_acc = 7'd0;
    w_ovf_now  = 1'b0;
    for (int k = 0; k < REL_PORT; k++) begin
      w_wr_en[k]  = 1'b0;
      w_wr_idx[k] = r_tl + w_nrel_acc[PREG_BITS-1:0];
      w_wr_dat[k] = rel_flat[k*c_rel_w +: PREG_BITS];
      if (rel_flat[k*c_rel_w + PREG_BITS]) begin
        if (w_nrel_acc < w_room) begin
          w_wr_en[k] = 1'b1;
          w_nrel_acc = w_nrel_acc + 7'd1;
        end else begin
          w_ovf_now = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        r_mem[i] <= (i < CAP) ? PREG_BITS'(i + ARCH_REG_NUM) : '0;
      end
      r_hd      <= '0;
      r_tl      <= PREG_BITS'(CAP);
      r_fre_cnt <= c_cap;
      r_ovf     <= 1'b0;
    end else begin
      for (int k = 0; k < REL_PORT; k++) begin
        if (w_wr_en[k]) begin
          r_mem[w_wr_idx[k]] <= w_wr_dat[k];
        end
      end
      r_hd      <= r_hd + (w_alc_gnt ? PREG_BITS'(alc_cnt) : '0);
      r_tl      <= r_tl + w_nrel_acc[PREG_BITS-1:0];
      r_fre_cnt <= r_fre_cnt + w_nrel_acc - w_granted;
      r_ovf     <= r_ovf | w_ovf_now;
    end
  end

  // Head window is always presented, granted or not.
  for (genvar j = 0; j < ALC_PORT; j++) begin : g_alc
    logic [PREG_BITS-1:0] w_rd_idx;
    assign w_rd_idx = r_hd + PREG_BITS'(j);
    assign alc_preg_flat[j*PREG_BITS +: PREG_BITS] = r_mem[w_rd_idx];
  end

  assign alc_gnt = w_alc_gnt;
  assign fre_cnt = r_fre_cnt;
  assign lst_emp = (r_fre_cnt == 7'd0);
  assign ovf_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fre_lst.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_fre_lst : self-checking bench for fre_lst with a queue model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fre_lst;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] rel_flat;
  logic [2:0]  alc_cnt;
  logic        alc_gnt;
  logic [23:0] alc_preg_flat;
  logic [6:0]  fre_cnt;
  logic        lst_emp;
  logic        ovf_err;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [5:0]  sb [$];
  logic        m_ovf;

  fre_lst dut (
    .clk           (clk),
    .rst           (rst),
    .rel_flat      (rel_flat),
    .alc_cnt       (alc_cnt),
    .alc_gnt       (alc_gnt),
    .alc_preg_flat (alc_preg_flat),
    .fre_cnt       (fre_cnt),
    .lst_emp       (lst_emp),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] mkrel(input logic [3:0] v, input logic [5:0] p0,
                                        input logic [5:0] p1, input logic [5:0] p2,
                                        input logic [5:0] p3);
    return {v[3], p3, v[2], p2, v[1], p1, v[0], p0};
  endfunction

  function automatic logic [5:0] port(input int j);
    return alc_preg_flat[j*6 +: 6];
  endfunction

  // Advance one edge and apply the same cycle to the reference queue.
  task automatic tick();
    int room;
    int acc;
    bit g;
    g = (alc_cnt != 0) && (int'(alc_cnt) <= sb.size()) && (alc_cnt <= 4);
    if (g) repeat (int'(alc_cnt)) void'(sb.pop_front());
    room = 48 - sb.size();
    acc  = 0;
    for (int k = 0; k < 4; k++) begin
      if (rel_flat[k*7 + 6]) begin
        if (acc < room) begin
          sb.push_back(rel_flat[k*7 +: 6]);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 16; i < 64; i++) sb.push_back(6'(i));
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rel_flat = '0; alc_cnt = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (fre_cnt !== 7'd48) begin n_fail++; $display("FAIL rst_cnt: got %0d want 48", fre_cnt); end
    n_chk++; if (lst_emp !== 1'b0) begin n_fail++; $display("FAIL rst_emp: got %0b want 0", lst_emp); end
    n_chk++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b want 0", ovf_err); end
    n_chk++; if (alc_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %0b want 0", alc_gnt); end
    n_chk++; if (alc_preg_flat !== {6'd19, 6'd18, 6'd17, 6'd16}) begin
      n_fail++; $display("FAIL rst_pregs: got %h want %h", alc_preg_flat, {6'd19, 6'd18, 6'd17, 6'd16});
    end
    alc_cnt = 3'd4;
    #1;
    n_chk++; if (alc_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_gnt4: got %0b want 1", alc_gnt); end
    tick();
    alc_cnt = 3'd0;
    #1;
    n_chk++; if (fre_cnt !== 7'd44) begin n_fail++; $display("FAIL alloc1_cnt: got %0d want 44", fre_cnt); end
    n_chk++; if (port(0) !== 6'd20) begin n_fail++; $display("FAIL alloc1_p0: got %0d want 20", port(0)); end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 11; c++) begin
      alc_cnt = 3'd4;
      #1;
      n_chk++; if (alc_gnt !== 1'b1) begin n_fail++; $display("FAIL drain_gnt c%0d: got %0b want 1", c, alc_gnt); end
      for (int j = 0; j < 4; j++) begin
        n_chk++; if (port(j) !== sb[j]) begin
          n_fail++; $display("FAIL drain_port c%0d p%0d: got %0d want %0d", c, j, port(j), sb[j]);
        end
      end
      tick();
    end
    alc_cnt = 3'd1;
    #1;
    n_chk++; if (alc_gnt !== 1'b0) begin n_fail++; $display("FAIL empty_gnt: got %0b want 0", alc_gnt); end
    n_chk++; if (lst_emp !== 1'b1) begin n_fail++; $display("FAIL empty_flag: got %0b want 1", lst_emp); end
    n_chk++; if (fre_cnt !== 7'd0) begin n_fail++; $display("FAIL empty_cnt: got %0d want 0", fre_cnt); end
    tick();
    alc_cnt = 3'd0;
    #1;
    n_chk++; if (fre_cnt !== 7'd0) begin n_fail++; $display("FAIL deny_cnt: got %0d want 0", fre_cnt); end
  endtask

  task automatic test_release_sparse();
    rel_flat = mkrel(4'b1010, 6'd0, 6'd5, 6'd0, 6'd9);
    alc_cnt  = 3'd0;
    tick();
    rel_flat = '0;
    #1;
    n_chk++; if (fre_cnt !== 7'(sb.size())) begin n_fail++; $display("FAIL sparse_cnt: got %0d want %0d", fre_cnt, sb.size()); end
    n_chk++; if (port(0) !== 6'd5) begin n_fail++; $display("FAIL sparse_p0: got %0d want 5", port(0)); end
    n_chk++; if (port(1) !== 6'd9) begin n_fail++; $display("FAIL sparse_p1: got %0d want 9", port(1)); end
    alc_cnt = 3'd2;
    #1;
    n_chk++; if (alc_gnt !== 1'b1) begin n_fail++; $display("FAIL sparse_gnt: got %0b want 1", alc_gnt); end
    tick();
    alc_cnt = 3'd0;
    #1;
    n_chk++; if (lst_emp !== 1'b1) begin n_fail++; $display("FAIL sparse_emp: got %0b want 1", lst_emp); end
  endtask

  task automatic test_no_bypass();
    rel_flat = mkrel(4'b0001, 6'd7, 6'd0, 6'd0, 6'd0);
    alc_cnt  = 3'd1;
    #1;
    n_chk++; if (alc_gnt !== 1'b0) begin n_fail++; $display("FAIL bypass_gnt: got %0b want 0", alc_gnt); end
    tick();
    rel_flat = '0;
    #1;
    n_chk++; if (alc_gnt !== 1'b1) begin n_fail++; $display("FAIL nb_gnt: got %0b want 1", alc_gnt); end
    n_chk++; if (port(0) !== 6'd7) begin n_fail++; $display("FAIL nb_p0: got %0d want 7", port(0)); end
    tick();
    alc_cnt = 3'd0;
    #1;
    n_chk++; if (fre_cnt !== 7'd0) begin n_fail++; $display("FAIL nb_cnt: got %0d want 0", fre_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    alc_cnt  = 3'd2;
    rel_flat = mkrel(4'b0001, 6'd3, 6'd0, 6'd0, 6'd0);
    #1;
    n_chk++; if (alc_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt: got %0b want 1", alc_gnt); end
    tick();
    alc_cnt  = 3'd0;
    rel_flat = '0;
    #1;
    n_chk++; if (fre_cnt !== 7'd47) begin n_fail++; $display("FAIL full_cnt47: got %0d want 47", fre_cnt); end
    n_chk++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL full_noovf: got %0b want 0", ovf_err); end
    rel_flat = mkrel(4'b0001, 6'd4, 6'd0, 6'd0, 6'd0);
    tick();
    rel_flat = mkrel(4'b0011, 6'd5, 6'd6, 6'd0, 6'd0);
    alc_cnt  = 3'd5;
    #1;
    n_chk++; if (alc_gnt !== 1'b0) begin n_fail++; $display("FAIL gnt_over_ports: got %0b want 0", alc_gnt); end
    tick();
    rel_flat = '0;
    alc_cnt  = 3'd0;
    #1;
    n_chk++; if (ovf_err !== m_ovf) begin n_fail++; $display("FAIL ovf_set: got %0b want %0b", ovf_err, m_ovf); end
    n_chk++; if (fre_cnt !== 7'd48) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 48", fre_cnt); end
    tick();
    n_chk++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", ovf_err); end
    // Reset wins over a simultaneous allocation and release.
    rst      = 1'b1;
    alc_cnt  = 3'd4;
    rel_flat = mkrel(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4);
    @(posedge clk);
    #1;
    rst = 1'b0; alc_cnt = 3'd0; rel_flat = '0;
    model_reset();
    #1;
    n_chk++; if (fre_cnt !== 7'd48) begin n_fail++; $display("FAIL rstov_cnt: got %0d want 48", fre_cnt); end
    n_chk++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rstov_ovf: got %0b want 0", ovf_err); end
    n_chk++; if (port(0) !== 6'd16) begin n_fail++; $display("FAIL rstov_p0: got %0d want 16", port(0)); end
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    bit         exp_g;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v        = 4'b1111 & ~(4'b0001 << (i % 4));
      alc_cnt  = 3'd4;
      rel_flat = mkrel(v, 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
      #1;
      exp_g = (sb.size() >= 4);
      n_chk++; if (alc_gnt !== exp_g) begin n_fail++; $display("FAIL wrap_gnt c%0d: got %0b want %0b", i, alc_gnt, exp_g); end
      n_chk++; if (fre_cnt !== 7'(sb.size())) begin n_fail++; $display("FAIL wrap_cnt c%0d: got %0d want %0d", i, fre_cnt, sb.size()); end
      for (int j = 0; j < 4; j++) begin
        if (j < sb.size()) begin
          n_chk++; if (port(j) !== sb[j]) begin
            n_fail++; $display("FAIL wrap_port c%0d p%0d: got %0d want %0d", i, j, port(j), sb[j]);
          end
        end
      end
      tick();
    end
    alc_cnt  = 3'd0;
    rel_flat = '0;
    #1;
    n_chk++; if (fre_cnt !== 7'(sb.size())) begin n_fail++; $display("FAIL wrap_end_cnt: got %0d want %0d", fre_cnt, sb.size()); end
    n_chk++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %0b want 0", ovf_err); end
  endtask

  initial begin
    rst = 1'b1; rel_flat = '0; alc_cnt = 3'd0; m_ovf = 1'b0;
    test_reset();
    test_drain();
    test_release_sparse();
    test_no_bypass();
    test_overflow();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
